// File: rtl/copy_descriptor_queue.sv
// copy_descriptor_queue: queues copy descriptors from the RISC, feeds the block copier one at a time and posts tagged checksums
module copy_descriptor_queue #(
    parameter int DESC_LOG2 = 3,
    parameter int DONE_LOG2 = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [31:0]          wq,
    input  logic                 wrS,
    input  logic                 wrD,
    input  logic                 wrL,
    output logic                 descFull,
    output logic [DESC_LOG2:0]   descCount,
    output logic                 overflow,
    output logic [31:0]          copyWq,
    output logic                 loadS,
    output logic                 loadD,
    output logic                 loadL,
    input  logic [16:0]          chkBusy,
    output logic                 doneValid,
    output logic [31:0]          doneData,
    input  logic                 donePop,
    output logic                 active
);
    localparam int DESC_DEPTH = 1 << DESC_LOG2;
    localparam int DONE_DEPTH = 1 << DONE_LOG2;

    typedef enum logic [2:0] {IDLE, ISSUE_S, ISSUE_D, ISSUE_L, WAIT_START, WAIT_DONE, POST} state_t;

    state_t             state;
    logic [30:0]        staging_s;
    logic [30:0]        staging_d;
    logic [7:0]         tag;
    logic [7:0]         cur_tag;
    logic [15:0]        sum;
    logic [1:0]         wait_cnt;
    logic [100:0]       desc_mem [DESC_DEPTH];
    logic [DESC_LOG2:0] desc_wr;
    logic [DESC_LOG2:0] desc_rd;
    logic [31:0]        done_mem [DONE_DEPTH];
    logic [DONE_LOG2:0] done_wr;
    logic [DONE_LOG2:0] done_rd;
    logic [DONE_LOG2:0] done_count;
    logic [7:0]         head_tag;
    logic [30:0]        head_s;
    logic [30:0]        head_d;
    logic [30:0]        head_l;
    logic               desc_empty;
    logic               desc_ready;
    logic               desc_push;
    logic               desc_pop;
    logic               done_full;
    logic               done_push;
    logic               done_pop;
    logic               unused_wq;

    assign unused_wq = wq[31];

    // Descriptor FIFO status; the extra pointer bit makes the MSB of the occupancy the full flag
    assign descCount  = desc_wr - desc_rd;
    assign descFull   = descCount[DESC_LOG2];
    assign desc_empty = descCount == '0;
    assign {head_tag, head_s, head_d, head_l} = desc_mem[desc_rd[DESC_LOG2-1:0]];

    // A descriptor may start only when the copier itself reports idle
    assign desc_ready = !desc_empty && !chkBusy[0];

    // Zero-length descriptors are retired straight from IDLE; others leave the FIFO once L is loaded
    assign desc_pop  = (state == ISSUE_L) || (state == IDLE && desc_ready && head_l == '0);

    // A full FIFO still takes a commit when the head is leaving in the same cycle
    assign desc_push = wrL && (!descFull || desc_pop);

    assign done_count = done_wr - done_rd;
    assign done_full  = done_count[DONE_LOG2];
    assign doneValid  = done_count != '0;
    assign doneData   = doneValid ? done_mem[done_rd[DONE_LOG2-1:0]] : '0;
    assign done_push  = state == POST && !done_full;
    assign done_pop   = donePop && doneValid;

    // Staging registers, commit pointer, tag counter and sticky overflow
    always_ff @(posedge clock) begin
        if (reset) begin
            staging_s <= '0;
            staging_d <= '0;
            desc_wr   <= '0;
            tag       <= '0;
            overflow  <= 1'b0;
        end else begin
            if (wrS) staging_s <= wq[30:0];
            if (wrD) staging_d <= wq[30:0];
            if (desc_push) begin
                desc_wr <= desc_wr + 1'b1;
                tag     <= tag + 8'd1;
            end
            if (wrL && !desc_push) overflow <= 1'b1;
        end
    end

    // Descriptor storage; a same-cycle wrS/wrD still commits the pre-edge staging values
    always_ff @(posedge clock) begin
        if (desc_push) desc_mem[desc_wr[DESC_LOG2-1:0]] <= {tag, staging_s, staging_d, wq[30:0]};
    end

    // Descriptor read pointer advances when the FSM retires the head
    always_ff @(posedge clock) begin
        if (reset) desc_rd <= '0;
        else if (desc_pop) desc_rd <= desc_rd + 1'b1;
    end

    // Completion FIFO pointers; push and pop are independent
    always_ff @(posedge clock) begin
        if (reset) begin
            done_wr <= '0;
            done_rd <= '0;
        end else begin
            if (done_push) done_wr <= done_wr + 1'b1;
            if (done_pop) done_rd <= done_rd + 1'b1;
        end
    end

    // Completion storage: tag in the top byte, checksum in the low half
    always_ff @(posedge clock) begin
        if (done_push) done_mem[done_wr[DONE_LOG2-1:0]] <= {cur_tag, 8'h00, sum};
    end

    // Issue sequencer: S, D, then L (the copier starts on a non-zero L), wait out the copy, post the result
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            loadS    <= 1'b0;
            loadD    <= 1'b0;
            loadL    <= 1'b0;
            copyWq   <= '0;
            active   <= 1'b0;
            cur_tag  <= '0;
            sum      <= '0;
            wait_cnt <= '0;
        end else begin
            loadS  <= 1'b0;
            loadD  <= 1'b0;
            loadL  <= 1'b0;
            copyWq <= '0;
            case (state)
                IDLE: begin
                    if (desc_ready) begin
                        cur_tag <= head_tag;
                        active  <= 1'b1;
                        if (head_l == '0) begin
                            sum   <= 16'hFFFF;
                            state <= POST;
                        end else begin
                            loadS  <= 1'b1;
                            copyWq <= {1'b0, head_s};
                            state  <= ISSUE_S;
                        end
                    end
                end
                ISSUE_S: begin
                    loadD  <= 1'b1;
                    copyWq <= {1'b0, head_d};
                    state  <= ISSUE_D;
                end
                ISSUE_D: begin
                    loadL  <= 1'b1;
                    copyWq <= {1'b0, head_l};
                    state  <= ISSUE_L;
                end
                ISSUE_L: begin
                    wait_cnt <= '0;
                    state    <= WAIT_START;
                end
                WAIT_START: begin
                    if (chkBusy[0] || wait_cnt == 2'd3) state <= WAIT_DONE;
                    else wait_cnt <= wait_cnt + 2'd1;
                end
                WAIT_DONE: begin
                    if (!chkBusy[0]) begin
                        sum   <= chkBusy[16:1];
                        state <= POST;
                    end
                end
                POST: begin
                    if (!done_full) begin
                        active <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    active <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule
